// File: rtl/pipe_stage_skid_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid_reg
//
// Generic inter-stage pipeline register with a valid/ready handshake and a
// 2-entry skid buffer (main + skid). Because in_ready is taken from a
// register, downstream back-pressure never forms a combinational path to
// upstream. A synchronous flush kills the stage contents and leaves a zeroed
// bubble. Two saturating counters record stall cycles and bubble cycles.
//
// Ports:
//   clk        in   stage clock, all state on the rising edge
//   reset      in   synchronous active-high reset, clears all state
//   flush      in   synchronous kill of stage contents
//   in_valid   in   upstream offers in_data/in_ctrl
//   in_ready   out  stage can accept (registered)
//   in_data    in   upstream data payload  [DATA_W]
//   in_ctrl    in   upstream control payload [CTRL_W]
//   out_valid  out  out_data/out_ctrl hold a live instruction (registered)
//   out_ready  in   downstream accepts
//   out_data   out  registered data payload [DATA_W]
//   out_ctrl   out  registered control payload [CTRL_W], zero when not valid
//   occupancy  out  number of entries held (0, 1 or 2)
//   stall_cnt  out  saturating count of out_valid=1 & out_ready=0 cycles
//   bubble_cnt out  saturating count of out_valid=0 & out_ready=1 cycles
// -----------------------------------------------------------------------------
module pipe_stage_skid_reg #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 13,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  bubble_cnt
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_e;

   state_e              state_q,      state_d;
   logic [DATA_W-1:0]   main_data_q,  main_data_d;
   logic [CTRL_W-1:0]   main_ctrl_q,  main_ctrl_d;
   logic [DATA_W-1:0]   skid_data_q,  skid_data_d;
   logic [CTRL_W-1:0]   skid_ctrl_q,  skid_ctrl_d;
   logic                out_valid_q,  out_valid_d;
   logic                in_ready_q,   in_ready_d;
   logic [CNT_W-1:0]    stall_q,      stall_d;
   logic [CNT_W-1:0]    bubble_q,     bubble_d;

   logic                in_fire_s;
   logic                out_fire_s;

   // Handshakes are formed from the registered ready/valid flags only.
   assign in_fire_s  = in_valid  & in_ready_q;
   assign out_fire_s = out_valid_q & out_ready;

   // Next-state logic for occupancy, payload storage and counters.
   always_comb begin
      state_d     = state_q;
      main_data_d = main_data_q;
      main_ctrl_d = main_ctrl_q;
      skid_data_d = skid_data_q;
      skid_ctrl_d = skid_ctrl_q;

      case (state_q)
         ST_EMPTY: begin
            if (in_fire_s) begin
               state_d     = ST_ONE;
               main_data_d = in_data;
               main_ctrl_d = in_ctrl;
            end else begin
               state_d = ST_EMPTY;
            end
         end
         ST_ONE: begin
            if (in_fire_s && out_fire_s) begin
               main_data_d = in_data;
               main_ctrl_d = in_ctrl;
            end else if (in_fire_s) begin
               // Downstream stalled: park the newcomer behind main.
               state_d     = ST_TWO;
               skid_data_d = in_data;
               skid_ctrl_d = in_ctrl;
            end else if (out_fire_s) begin
               // Main empties, so the outputs read as a zero bubble.
               state_d     = ST_EMPTY;
               main_data_d = '0;
               main_ctrl_d = '0;
            end else begin
               state_d = ST_ONE;
            end
         end
         ST_TWO: begin
            // in_ready is low here, so only a drain can happen.
            if (out_fire_s) begin
               state_d     = ST_ONE;
               main_data_d = skid_data_q;
               main_ctrl_d = skid_ctrl_q;
               skid_data_d = '0;
               skid_ctrl_d = '0;
            end else begin
               state_d = ST_TWO;
            end
         end
         default: begin
            state_d     = ST_EMPTY;
            main_data_d = '0;
            main_ctrl_d = '0;
            skid_data_d = '0;
            skid_ctrl_d = '0;
         end
      endcase

      // Flush overrides any handshake in the same cycle.
      if (flush) begin
         state_d     = ST_EMPTY;
         main_data_d = '0;
         main_ctrl_d = '0;
         skid_data_d = '0;
         skid_ctrl_d = '0;
      end else begin
         state_d = state_d;
      end

      out_valid_d = (state_d != ST_EMPTY);
      in_ready_d  = (state_d != ST_TWO);

      // Counters look at the pre-edge flags and stop at all-ones.
      if (out_valid_q && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
         stall_d = stall_q + CNT_W'(1);
      end else begin
         stall_d = stall_q;
      end

      if (!out_valid_q && out_ready && (bubble_q != {CNT_W{1'b1}})) begin
         bubble_d = bubble_q + CNT_W'(1);
      end else begin
         bubble_d = bubble_q;
      end
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_EMPTY;
         main_data_q <= '0;
         main_ctrl_q <= '0;
         skid_data_q <= '0;
         skid_ctrl_q <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         stall_q     <= '0;
         bubble_q    <= '0;
      end else begin
         state_q     <= state_d;
         main_data_q <= main_data_d;
         main_ctrl_q <= main_ctrl_d;
         skid_data_q <= skid_data_d;
         skid_ctrl_q <= skid_ctrl_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         stall_q     <= stall_d;
         bubble_q    <= bubble_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign out_valid  = out_valid_q;
   assign out_data   = main_data_q;
   assign out_ctrl   = main_ctrl_q;
   assign occupancy  = state_q;
   assign stall_cnt  = stall_q;
   assign bubble_cnt = bubble_q;

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
module tb_pipe_stage_skid_reg;

   localparam int DATA_W = 32;
   localparam int CTRL_W = 13;
   localparam int CNT_W  = 4;

   logic              clk = 1'b0;
   logic              reset, flush, in_valid, in_ready, out_valid, out_ready;
   logic [DATA_W-1:0] in_data, out_data;
   logic [CTRL_W-1:0] in_ctrl, out_ctrl;
   logic [1:0]        occupancy;
   logic [CNT_W-1:0]  stall_cnt, bubble_cnt;

   int total = 0;
   int bad   = 0;

   pipe_stage_skid_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_ctrl    (in_ctrl),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_ctrl   (out_ctrl),
      .occupancy  (occupancy),
      .stall_cnt  (stall_cnt),
      .bubble_cnt (bubble_cnt)
   );

   always #5 clk = ~clk;

   // One clock edge, then settle before inputs change or outputs are sampled.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_data = '0; in_ctrl = '0;
      step();
      reset = 1'b0;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_occ"},   64'(occupancy), 64'd0);
      chk({tag, "_ovld"},  64'(out_valid), 64'd0);
      chk({tag, "_irdy"},  64'(in_ready),  64'd1);
      chk({tag, "_odata"}, 64'(out_data),  64'd0);
      chk({tag, "_octrl"}, 64'(out_ctrl),  64'd0);
   endtask

   initial begin
      // ---------------- 1: reset state and back-to-back stream -------------
      do_reset();
      chk_idle("rst");
      chk("rst_stall",  64'(stall_cnt),  64'd0);
      chk("rst_bubble", 64'(bubble_cnt), 64'd0);

      in_valid = 1'b1; in_data = 32'h0000_0004; in_ctrl = 13'h0011; out_ready = 1'b1;
      step();
      chk("t1_ovld",  64'(out_valid), 64'd1);
      chk("t1_data",  64'(out_data),  64'h4);
      chk("t1_ctrl",  64'(out_ctrl),  64'h11);
      for (int i = 0; i < 8; i++) begin
         in_data = 32'h100 + 32'(i);
         in_ctrl = 13'(i + 1);
         step();
         chk("t1_stream_data", 64'(out_data),  64'h100 + 64'(i));
         chk("t1_stream_ctrl", 64'(out_ctrl),  64'(i + 1));
         chk("t1_stream_occ",  64'(occupancy), 64'd1);
      end
      in_valid = 1'b0;
      step();
      chk_idle("t1_drain");
      chk("t1_stall",  64'(stall_cnt),  64'd0);
      chk("t1_bubble", 64'(bubble_cnt), 64'd1);

      // ---------------- 2: back-pressure into the skid ----------------------
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 32'hA; in_ctrl = 13'h00A;
      step();
      chk("t2_occ1", 64'(occupancy), 64'd1);
      in_data = 32'hB; in_ctrl = 13'h00B;
      step();
      chk("t2_occ2", 64'(occupancy), 64'd2);
      chk("t2_irdy", 64'(in_ready),  64'd0);
      in_data = 32'hC; in_ctrl = 13'h00C;
      step();
      step();
      chk("t2_occ_hold", 64'(occupancy), 64'd2);
      chk("t2_stall",    64'(stall_cnt), 64'd3);
      chk("t2_dataA",    64'(out_data),  64'hA);
      out_ready = 1'b1;
      step();
      chk("t2_dataB", 64'(out_data),  64'hB);
      chk("t2_ctrlB", 64'(out_ctrl),  64'hB);
      chk("t2_occB",  64'(occupancy), 64'd1);
      chk("t2_irdyB", 64'(in_ready),  64'd1);
      step();
      chk("t2_dataC", 64'(out_data),  64'hC);
      chk("t2_occC",  64'(occupancy), 64'd1);
      in_valid = 1'b0;
      step();
      chk_idle("t2_drain");
      chk("t2_stall_end", 64'(stall_cnt), 64'd3);

      // ---------------- 3: flush while full ---------------------------------
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 32'h1A; in_ctrl = 13'h01A;
      step();
      in_data = 32'h1B; in_ctrl = 13'h01B;
      step();
      chk("t3_full", 64'(occupancy), 64'd2);
      flush = 1'b1; out_ready = 1'b1; in_data = 32'hD; in_ctrl = 13'h00D;
      step();
      chk_idle("t3_flush");
      flush = 1'b0; in_valid = 1'b0;
      step();
      chk("t3_noD_vld",  64'(out_valid), 64'd0);
      chk("t3_noD_data", 64'(out_data),  64'd0);

      // ---------------- 4: bubble counter saturation ------------------------
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 14; i++) step();
      chk("t4_bubble14", 64'(bubble_cnt), 64'd14);
      step();
      chk("t4_bubble15", 64'(bubble_cnt), 64'hF);
      for (int i = 0; i < 6; i++) step();
      chk("t4_bubble_sat", 64'(bubble_cnt), 64'hF);

      // ---------------- 5: reset from TWO with stall_cnt=7 ------------------
      do_reset();
      in_valid = 1'b1; in_data = 32'h5A; in_ctrl = 13'h05A;
      step();
      in_data = 32'h5B; in_ctrl = 13'h05B;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 6; i++) step();
      chk("t5_occ2",  64'(occupancy), 64'd2);
      chk("t5_stall", 64'(stall_cnt), 64'd7);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk_idle("t5_rst");
      chk("t5_rst_stall",  64'(stall_cnt),  64'd0);
      chk("t5_rst_bubble", 64'(bubble_cnt), 64'd0);
      in_valid = 1'b1; in_data = 32'hE; in_ctrl = 13'h00E; out_ready = 1'b1;
      step();
      chk("t5_ovld", 64'(out_valid), 64'd1);
      chk("t5_data", 64'(out_data),  64'hE);

      // ---------------- 6: steady pass-through in ONE -----------------------
      for (int i = 0; i < 5; i++) begin
         in_data = 32'hC0DE_0000 + 32'(i);
         in_ctrl = 13'h100 + 13'(i);
         step();
         chk("t6_occ",  64'(occupancy), 64'd1);
         chk("t6_irdy", 64'(in_ready),  64'd1);
         chk("t6_data", 64'(out_data),  64'hC0DE_0000 + 64'(i));
         chk("t6_ctrl", 64'(out_ctrl),  64'h100 + 64'(i));
      end
      // Payload changes with in_valid low must not reach main.
      in_valid = 1'b0; out_ready = 1'b0; in_data = 32'hDEAD_BEEF; in_ctrl = 13'h1FFF;
      step();
      chk("t6_hold_data", 64'(out_data), 64'hC0DE_0004);
      chk("t6_hold_ctrl", 64'(out_ctrl), 64'h104);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
